// File: rtl/pht_gshare_pkg.sv
// Shared LC-3b type/constant package: default sizing for the pattern history table.
package lc3b_types;

    localparam int PHT_CTR_W   = 2;
    localparam int PHT_INDEX_W = 7;
    localparam int PHT_GHR_W   = 7;

    typedef logic [PHT_INDEX_W-1:0] pht_index_t;

endpackage

// File: rtl/pht_gshare_ctr_next.sv
// Saturating up/down counter next-state logic for one PHT entry, any width.
module pht_ctr_next #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             taken,
    output logic [CTR_W-1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != '1) ctr_next = ctr + CTR_W'(1);
        end else begin
            if (ctr != '0) ctr_next = ctr - CTR_W'(1);
        end
    end

endmodule

// File: rtl/pht_gshare.sv
// Pattern history table with optional gshare hashing (define PHT_GSHARE_EN).
// Lookup is combinational; training and history shift happen on resolved branches.
module pht_gshare
    import lc3b_types::*;
#(
    parameter int CTR_W   = PHT_CTR_W,
    parameter int INDEX_W = PHT_INDEX_W,
    parameter int GHR_W   = PHT_GHR_W,
    parameter int PC_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    pred_pc,
    output logic               pred_taken,
    output logic [INDEX_W-1:0] pred_index,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic               upd_taken,
    output logic [GHR_W-1:0]   ghr
);

    localparam int NENT = 1 << INDEX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic [CTR_W-1:0]   w_table [NENT];
    logic [CTR_W-1:0]   w_ctr_next;
    logic [GHR_W-1:0]   r_ghr;
    logic [GHR_W-1:0]   w_ghr_next;
    logic [INDEX_W-1:0] w_bimodal;
    logic               w_unused;

    // Only one entry trains per cycle, so a single next-state block is shared.
    pht_ctr_next #(.CTR_W(CTR_W)) u_ctr_next (
        .ctr      (w_table[upd_index]),
        .taken    (upd_taken),
        .ctr_next (w_ctr_next)
    );

    for (genvar i = 0; i < NENT; i++) begin : g_entry
        logic [CTR_W-1:0] r_ctr;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_ctr <= CTR_INIT;
            else if (upd_valid && upd_index == INDEX_W'(i))
                r_ctr <= w_ctr_next;
        end
        assign w_table[i] = r_ctr;
    end

    if (GHR_W == 1) begin : g_ghr1
        assign w_ghr_next = upd_taken;
    end else begin : g_ghrn
        assign w_ghr_next = {r_ghr[GHR_W-2:0], upd_taken};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ghr <= '0;
        else if (upd_valid)
            r_ghr <= w_ghr_next;
    end

    // PC bit 0 is always zero for word-aligned instructions.
    assign w_bimodal = pred_pc[INDEX_W:1];

`ifdef PHT_GSHARE_EN
    assign pred_index = w_bimodal ^ INDEX_W'(r_ghr);
`else
    assign pred_index = w_bimodal;
`endif

    assign pred_taken = w_table[pred_index][CTR_W-1];
    assign ghr        = r_ghr;

    if (PC_W > INDEX_W + 1) begin : g_pc_hi
        assign w_unused = ^{pred_pc[PC_W-1:INDEX_W+1], pred_pc[0]};
    end else begin : g_pc_lo
        assign w_unused = pred_pc[0];
    end

endmodule

// File: tb/tb_pht_gshare.sv
// Self-checking bench for pht_gshare: default instance plus a CTR_W=3 instance.
module tb_pht_gshare;

`ifdef PHT_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pred_pc = '0;
    logic        upd_valid = 1'b0;
    logic [6:0]  upd_index = '0;
    logic        upd_taken = 1'b0;
    logic        pred_taken;
    logic [6:0]  pred_index;
    logic [6:0]  ghr;

    logic [7:0]  pc3 = '0;
    logic        uv3 = 1'b0;
    logic [3:0]  ui3 = '0;
    logic        ut3 = 1'b0;
    logic        pt3;
    logic [3:0]  pi3;
    logic [2:0]  gh3;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: plain integers, saturated with arithmetic.
    int m_ctr [128];
    int m_ghr;
    int m3_ctr [16];
    int m3_ghr;

    always #5 clk = ~clk;

    pht_gshare dut (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_index(pred_index), .upd_valid(upd_valid), .upd_index(upd_index),
        .upd_taken(upd_taken), .ghr(ghr)
    );

    pht_gshare #(.CTR_W(3), .INDEX_W(4), .GHR_W(3), .PC_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .pred_pc(pc3), .pred_taken(pt3),
        .pred_index(pi3), .upd_valid(uv3), .upd_index(ui3),
        .upd_taken(ut3), .ghr(gh3)
    );

    function automatic int midx(input int pc);
        return ((pc >> 1) & 127) ^ (GS ? m_ghr : 0);
    endfunction

    function automatic int midx3(input int pc);
        return ((pc >> 1) & 15) ^ (GS ? m3_ghr : 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_ctr[i] = 1;
        for (int i = 0; i < 16; i++) m3_ctr[i] = 3;
        m_ghr  = 0;
        m3_ghr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        upd_valid = 1'b0;
        uv3 = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance one clock; model applies the same resolved-branch rules.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (upd_valid) begin
                if (upd_taken) m_ctr[upd_index] = (m_ctr[upd_index] == 3) ? 3 : m_ctr[upd_index] + 1;
                else           m_ctr[upd_index] = (m_ctr[upd_index] == 0) ? 0 : m_ctr[upd_index] - 1;
                m_ghr = ((m_ghr << 1) | int'(upd_taken)) & 127;
            end
            if (uv3) begin
                if (ut3) m3_ctr[ui3] = (m3_ctr[ui3] == 7) ? 7 : m3_ctr[ui3] + 1;
                else     m3_ctr[ui3] = (m3_ctr[ui3] == 0) ? 0 : m3_ctr[ui3] - 1;
                m3_ghr = ((m3_ghr << 1) | int'(ut3)) & 7;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [6:0] ei;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            ei = 7'(i);
            pred_pc = {8'($urandom), ei, 1'($urandom)};
            #1;
            n_cmp++;
            if (pred_taken !== 1'b0 || pred_index !== ei) begin
                n_bad++;
                $display("FAIL reset_sweep idx=%0d got taken=%0b index=%0d want taken=0 index=%0d",
                         i, pred_taken, pred_index, ei);
            end
        end
        n_cmp++;
        if (ghr !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_ghr got %0h want 0", ghr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        pred_pc = 16'h00fe;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pt3 !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset got %0b/%0b want 0/0", pred_taken, pt3);
        end
    endtask

    task automatic test_bimodal();
        logic exp_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic tk_seq  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int s = 0; s < 6; s++) begin
            upd_valid = 1'b1;
            upd_index = 7'd8;
            upd_taken = tk_seq[s];
            tick();
            upd_valid = 1'b0;
            pred_pc = 16'((8 ^ (GS ? m_ghr : 0)) << 1);
            #1;
            n_cmp++;
            if (pred_taken !== exp_seq[s] || pred_index !== 7'd8) begin
                n_bad++;
                $display("FAIL bimodal_step%0d got taken=%0b index=%0d want taken=%0b index=8",
                         s, pred_taken, pred_index, exp_seq[s]);
            end
        end
        pred_pc = 16'((9 ^ (GS ? m_ghr : 0)) << 1);
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL neighbour_hold got %0b want 0", pred_taken);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        pred_pc   = 16'h000a;
        upd_valid = 1'b1;
        upd_index = 7'd5;
        upd_taken = 1'b1;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL same_cycle_pre got %0b want 0", pred_taken);
        end
        tick();
        upd_valid = 1'b0;
        pred_pc = 16'((5 ^ (GS ? 1 : 0)) << 1);
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1) begin
            n_bad++;
            $display("FAIL same_cycle_post got %0b want 1", pred_taken);
        end
    endtask

    task automatic test_history();
        logic tk [3] = '{1'b1, 1'b0, 1'b1};
        do_reset();
        for (int s = 0; s < 3; s++) begin
            upd_valid = 1'b1;
            upd_index = 7'd100;
            upd_taken = tk[s];
            tick();
        end
        upd_valid = 1'b0;
        pred_pc = 16'h0010;
        #1;
        n_cmp++;
        if (ghr !== 7'b0000101) begin
            n_bad++;
            $display("FAIL history_ghr got %0h want 5", ghr);
        end
        n_cmp++;
        if (pred_index !== (GS ? 7'd13 : 7'd8)) begin
            n_bad++;
            $display("FAIL history_index got %0d want %0d", pred_index, GS ? 13 : 8);
        end
    endtask

    task automatic test_ctr3();
        do_reset();
        for (int s = 0; s < 12; s++) begin
            uv3 = 1'b1;
            ui3 = 4'd6;
            ut3 = (s < 8);
            tick();
            uv3 = 1'b0;
            pc3 = 8'((6 ^ (GS ? m3_ghr : 0)) << 1);
            #1;
            if (s == 0 || s == 7 || s == 10 || s == 11) begin
                n_cmp++;
                if (pt3 !== (s != 11)) begin
                    n_bad++;
                    $display("FAIL ctr3_step%0d got %0b want %0b", s, pt3, s != 11);
                end
            end
        end
        pc3 = 8'((7 ^ (GS ? m3_ghr : 0)) << 1);
        #1;
        n_cmp++;
        if (pt3 !== 1'b0) begin
            n_bad++;
            $display("FAIL ctr3_neighbour got %0b want 0", pt3);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            upd_valid = 1'b1;
            upd_index = 7'd20;
            upd_taken = 1'b1;
            uv3 = 1'b1;
            ui3 = 4'd2;
            ut3 = 1'b1;
            tick();
        end
        pred_pc = 16'd40;
        pc3 = 8'd4;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ghr !== 7'd0 || gh3 !== 3'd0 || pred_taken !== 1'b0 || pt3 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_async got ghr=%0h taken=%0b ghr3=%0h taken3=%0b want all 0",
                     ghr, pred_taken, gh3, pt3);
        end
        tick();
        model_reset();
        rst_n = 1'b1;
        upd_valid = 1'b0;
        uv3 = 1'b0;
        #1;
        n_cmp++;
        if (ghr !== 7'd0 || pred_taken !== 1'b0 || pt3 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_discard got ghr=%0h taken=%0b taken3=%0b want 0/0/0",
                     ghr, pred_taken, pt3);
        end
    endtask

    task automatic test_random();
        logic [6:0] ei;
        logic [3:0] ei3;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            pred_pc   = 16'($urandom);
            upd_valid = 1'($urandom);
            upd_index = 7'($urandom_range(0, 15));
            upd_taken = 1'($urandom);
            pc3 = 8'($urandom);
            uv3 = 1'($urandom);
            ui3 = 4'($urandom_range(0, 3));
            ut3 = 1'($urandom);
            ei  = 7'(midx(int'(pred_pc)));
            ei3 = 4'(midx3(int'(pc3)));
            #1;
            n_cmp++;
            if (pred_index !== ei || pred_taken !== (m_ctr[ei] >= 2) || ghr !== 7'(m_ghr)) begin
                n_bad++;
                $display("FAIL random_c%0d got index=%0d taken=%0b ghr=%0h want %0d/%0b/%0h",
                         c, pred_index, pred_taken, ghr, ei, m_ctr[ei] >= 2, m_ghr);
            end
            n_cmp++;
            if (pi3 !== ei3 || pt3 !== (m3_ctr[ei3] >= 4) || gh3 !== 3'(m3_ghr)) begin
                n_bad++;
                $display("FAIL random3_c%0d got index=%0d taken=%0b ghr=%0h want %0d/%0b/%0h",
                         c, pi3, pt3, gh3, ei3, m3_ctr[ei3] >= 4, m3_ghr);
            end
            tick();
        end
        upd_valid = 1'b0;
        uv3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bimodal();
        test_same_cycle();
        test_history();
        test_ctr3();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
